// File: rtl/instr_cache_refill.sv
// Instruction-cache line refill engine: fetches a missing line beat by beat,
// writes the data array, then the tag, and sweeps every tag invalid on flush.
module instr_cache_refill #(
  parameter int unsigned PADDR_WIDTH = 32,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned LINE_BEATS  = 8,
  parameter int unsigned BEAT_WIDTH  = 32,
  localparam int unsigned OFFSET_WIDTH = $clog2(LINE_BEATS * BEAT_WIDTH / 8),
  localparam int unsigned TAG_WIDTH    = PADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int unsigned BEAT_IDX     = $clog2(LINE_BEATS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_miss_valid,
  input  logic [PADDR_WIDTH-1:0] i_miss_paddr,
  output logic                   o_miss_ready,
  input  logic                   i_flush,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [PADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                   i_mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0]  i_mem_resp_data,
  output logic                   o_data_we,
  output logic [INDEX_WIDTH-1:0] o_data_index,
  output logic [BEAT_IDX-1:0]    o_data_beat,
  output logic [BEAT_WIDTH-1:0]  o_data_wdata,
  output logic                   o_tag_we,
  output logic [INDEX_WIDTH-1:0] o_tag_index,
  output logic [TAG_WIDTH-1:0]   o_tag_value,
  output logic                   o_tag_valid,
  output logic                   o_refill_done,
  output logic                   o_busy
);

  localparam int unsigned LINE_WIDTH = PADDR_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_TAG,
    S_FLUSH
  } state_e;

  state_e                 state_q, state_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic [BEAT_IDX-1:0]    beat_q, beat_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [INDEX_WIDTH-1:0] line_index;
  logic [TAG_WIDTH-1:0]   line_tag;
  logic                   unused_offset;

  // Only the line address is kept; the byte offset within the line is dropped.
  assign line_index    = line_q[INDEX_WIDTH-1:0];
  assign line_tag      = line_q[LINE_WIDTH-1:INDEX_WIDTH];
  assign unused_offset = ^i_miss_paddr[OFFSET_WIDTH-1:0];

  // Reset parks the FSM in FLUSH so release starts a full invalidation sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_FLUSH;
      line_q  <= '0;
      beat_q  <= '0;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    beat_d          = beat_q;
    sweep_d         = sweep_q;
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_data_we       = 1'b0;
    o_data_index    = '0;
    o_data_beat     = '0;
    o_data_wdata    = '0;
    o_tag_we        = 1'b0;
    o_tag_index     = '0;
    o_tag_value     = '0;
    o_tag_valid     = 1'b0;
    o_refill_done   = 1'b0;
    o_busy          = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        o_miss_ready = !i_flush;
        if (i_flush) begin
          state_d = S_FLUSH;
          sweep_d = '0;
        end else if (i_miss_valid) begin
          state_d = S_REQ;
          line_d  = i_miss_paddr[PADDR_WIDTH-1:OFFSET_WIDTH];
        end
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = {line_q, OFFSET_WIDTH'(0)};
        if (i_mem_req_ready) begin
          state_d = S_FILL;
          beat_d  = '0;
        end
      end
      S_FILL: begin
        if (i_mem_resp_valid) begin
          o_data_we    = 1'b1;
          o_data_index = line_index;
          o_data_beat  = beat_q;
          o_data_wdata = i_mem_resp_data;
          beat_d       = beat_q + BEAT_IDX'(1);
          if (beat_q == BEAT_IDX'(LINE_BEATS - 1)) begin
            state_d = S_TAG;
          end
        end
      end
      // Tag goes valid only once every beat of the line is in the data array.
      S_TAG: begin
        o_tag_we      = 1'b1;
        o_tag_index   = line_index;
        o_tag_value   = line_tag;
        o_tag_valid   = 1'b1;
        o_refill_done = 1'b1;
        state_d       = S_IDLE;
      end
      S_FLUSH: begin
        o_tag_we    = 1'b1;
        o_tag_index = sweep_q;
        sweep_d     = sweep_q + INDEX_WIDTH'(1);
        if (sweep_q == '1) begin
          o_refill_done = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet while reset is held, even though the FSM sits in FLUSH.
    if (!i_rst_n) begin
      o_miss_ready    = 1'b0;
      o_mem_req_valid = 1'b0;
      o_mem_req_addr  = '0;
      o_data_we       = 1'b0;
      o_data_index    = '0;
      o_data_beat     = '0;
      o_data_wdata    = '0;
      o_tag_we        = 1'b0;
      o_tag_index     = '0;
      o_tag_value     = '0;
      o_tag_valid     = 1'b0;
      o_refill_done   = 1'b0;
      o_busy          = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_cache_refill.sv
// Bench for instr_cache_refill: directed scenarios plus randomized refills and
// flushes checked against a line-level cache model and write logs.
module tb_instr_cache_refill;

  localparam int unsigned PW = 32;
  localparam int unsigned IW = 6;
  localparam int unsigned LB = 8;
  localparam int unsigned BW = 32;
  localparam int unsigned TW = 21;
  localparam int unsigned BI = 3;
  localparam int unsigned NSETS = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_valid = 1'b0;
  logic [PW-1:0] miss_paddr = '0;
  logic          flush = 1'b0;
  logic          req_ready = 1'b0;
  logic          resp_valid = 1'b0;
  logic [BW-1:0] resp_data = '0;

  logic          o_miss_ready, o_mem_req_valid, o_data_we, o_tag_we;
  logic          o_tag_valid, o_refill_done, o_busy;
  logic [PW-1:0] o_mem_req_addr;
  logic [IW-1:0] o_data_index, o_tag_index;
  logic [BI-1:0] o_data_beat;
  logic [BW-1:0] o_data_wdata;
  logic [TW-1:0] o_tag_value;

  instr_cache_refill #(
    .PADDR_WIDTH(PW), .INDEX_WIDTH(IW), .LINE_BEATS(LB), .BEAT_WIDTH(BW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_miss_valid(miss_valid), .i_miss_paddr(miss_paddr), .o_miss_ready(o_miss_ready),
    .i_flush(flush),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(req_ready), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_resp_valid(resp_valid), .i_mem_resp_data(resp_data),
    .o_data_we(o_data_we), .o_data_index(o_data_index), .o_data_beat(o_data_beat),
    .o_data_wdata(o_data_wdata),
    .o_tag_we(o_tag_we), .o_tag_index(o_tag_index), .o_tag_value(o_tag_value),
    .o_tag_valid(o_tag_valid), .o_refill_done(o_refill_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  wire [106:0] all_out = {o_miss_ready, o_mem_req_valid, o_mem_req_addr, o_data_we, o_data_index,
                          o_data_beat, o_data_wdata, o_tag_we, o_tag_index, o_tag_value,
                          o_tag_valid, o_refill_done, o_busy};

  typedef struct { int cyc; int idx; int beat; logic [BW-1:0] data; } dwr_t;
  typedef struct { int cyc; int idx; logic [TW-1:0] tag; logic valid; logic done; } twr_t;

  dwr_t          dlog[$];
  twr_t          tlog[$];
  logic [PW-1:0] alog[$];
  int            cyc = 0;
  int            viol = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  // Shadow of the arrays as written by the DUT, and the expected cache contents.
  logic          sh_valid [NSETS];
  logic [TW-1:0] sh_tag   [NSETS];
  logic [BW-1:0] sh_data  [NSETS][LB];
  logic          mv       [NSETS];
  logic [TW-1:0] mt       [NSETS];
  logic [BW-1:0] md       [NSETS][LB];
  logic [BW-1:0] beat_vals[LB];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (all_out !== '0) viol++;
    end else begin
      if (o_data_we && o_tag_we) viol++;
      if (!o_data_we && ({o_data_index, o_data_beat, o_data_wdata} !== '0)) viol++;
      if (!o_tag_we && ({o_tag_index, o_tag_value, o_tag_valid} !== '0)) viol++;
      if (o_refill_done && !o_tag_we) viol++;
      if (o_data_we) begin
        dlog.push_back('{cyc: cyc, idx: int'(o_data_index), beat: int'(o_data_beat), data: o_data_wdata});
        sh_data[o_data_index][o_data_beat] = o_data_wdata;
      end
      if (o_tag_we) begin
        tlog.push_back('{cyc: cyc, idx: int'(o_tag_index), tag: o_tag_value, valid: o_tag_valid,
                         done: o_refill_done});
        sh_tag[o_tag_index]   = o_tag_value;
        sh_valid[o_tag_index] = o_tag_valid;
      end
      if (o_mem_req_valid) alog.push_back(o_mem_req_addr);
    end
  end

  function automatic int set_of(input logic [PW-1:0] pa);
    return int'((pa >> 5) % NSETS);
  endfunction

  function automatic logic [TW-1:0] tag_of(input logic [PW-1:0] pa);
    return TW'(pa >> 11);
  endfunction

  function automatic void clear_logs();
    dlog.delete();
    tlog.delete();
    alog.delete();
  endfunction

  function automatic void model_invalidate_all();
    for (int s = 0; s < NSETS; s++) mv[s] = 1'b0;
  endfunction

  function automatic void model_commit(input logic [PW-1:0] pa);
    mv[set_of(pa)] = 1'b1;
    mt[set_of(pa)] = tag_of(pa);
    for (int k = 0; k < LB; k++) md[set_of(pa)][k] = beat_vals[k];
  endfunction

  // Number of ways the logged writes of one refill differ from the expected line fill.
  function automatic int refill_errs(input logic [PW-1:0] pa);
    int e;
    e = 0;
    if (dlog.size() != LB) e++;
    else for (int k = 0; k < LB; k++)
      if (dlog[k].idx != set_of(pa) || dlog[k].beat != k || dlog[k].data !== beat_vals[k]) e++;
    if (tlog.size() != 1) e++;
    else if (tlog[0].idx != set_of(pa) || tlog[0].tag !== tag_of(pa) || tlog[0].valid !== 1'b1 ||
             tlog[0].done !== 1'b1 || (dlog.size() == LB && tlog[0].cyc != dlog[LB-1].cyc + 1)) e++;
    if (alog.size() == 0) e++;
    foreach (alog[i]) if (alog[i] !== (pa & ~32'h1f)) e++;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete miss/request/fill transaction; starts and ends 1ns after a clock edge.
  task automatic run_refill(input logic [PW-1:0] pa, input int rdly, input int gap,
                            output bit to, output int acc_cyc);
    bit acc;
    int n;
    to = 1'b0;
    acc = 1'b0;
    acc_cyc = -1;
    n = 0;
    clear_logs();
    miss_valid = 1'b1;
    miss_paddr = pa;
    while (!acc && n < 300) begin
      #2;
      if (o_miss_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
      end
      next_cycle();
      n++;
    end
    miss_valid = 1'b0;
    miss_paddr = $urandom;
    if (!acc) begin
      to = 1'b1;
      return;
    end
    for (int d = 0; d < rdly; d++) begin
      resp_valid = 1'($urandom_range(0, 1));
      resp_data  = $urandom;
      flush      = 1'($urandom_range(0, 1));
      next_cycle();
    end
    req_ready = 1'b1;
    next_cycle();
    req_ready = 1'b0;
    for (int k = 0; k < LB; k++) begin
      int idle;
      idle = (gap == 1 && k > 0) ? 1 : (gap == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < idle; g++) begin
        resp_valid = 1'b0;
        resp_data  = $urandom;
        miss_valid = 1'($urandom_range(0, 1));
        flush      = 1'($urandom_range(0, 1));
        next_cycle();
      end
      resp_valid = 1'b1;
      resp_data  = beat_vals[k];
      flush      = 1'($urandom_range(0, 1));
      next_cycle();
    end
    resp_valid = 1'($urandom_range(0, 1));
    resp_data  = $urandom;
    miss_valid = 1'b0;
    flush      = 1'b0;
    next_cycle();
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] got, exp;
    rst_n = 1'b0;
    miss_valid = 1'b1;
    flush = 1'b1;
    resp_valid = 1'b1;
    miss_paddr = $urandom;
    repeat (3) next_cycle();
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    clear_logs();
    model_invalidate_all();
    rst_n = 1'b1;
    resp_valid = 1'b0;
    for (int k = 0; k < NSETS; k++) begin
      flush = 1'($urandom_range(0, 1));
      #2;
      got = {o_tag_we, o_tag_index, o_tag_value, o_tag_valid, o_refill_done, o_busy,
             o_miss_ready, o_data_we, o_mem_req_valid};
      exp = {1'b1, IW'(k), TW'(0), 1'b0, (k == NSETS - 1), 1'b1, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_sweep[%0d]: got %h expected %h", k, got, exp);
      end
      next_cycle();
    end
    miss_valid = 1'b0;
    flush = 1'b0;
    #2;
    n_cmp++;
    if ({o_miss_ready, o_busy, o_tag_we} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_idle: got %b expected 100", {o_miss_ready, o_busy, o_tag_we});
    end
    next_cycle();
  endtask

  task automatic test_refill();
    logic [PW+1:0] rg, re;
    logic [43:0]   dg, de;
    logic [29:0]   tg, te;
    for (int k = 0; k < LB; k++) beat_vals[k] = 32'hA0 + BW'(k);
    clear_logs();
    miss_valid = 1'b1;
    miss_paddr = 32'h0000_1234;
    #2;
    n_cmp++;
    if (o_miss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL refill_accept: got %b expected 1", o_miss_ready);
    end
    next_cycle();
    miss_valid = 1'b0;
    miss_paddr = 32'hDEAD_BEEF;
    for (int d = 0; d < 4; d++) begin
      req_ready  = (d == 3);
      resp_valid = 1'b1;
      resp_data  = $urandom;
      #2;
      rg = {o_mem_req_valid, o_mem_req_addr, o_data_we};
      re = {1'b1, 32'h0000_1220, 1'b0};
      n_cmp++;
      if (rg !== re) begin
        n_err++;
        $display("FAIL refill_req[%0d]: got %h expected %h", d, rg, re);
      end
      next_cycle();
    end
    req_ready = 1'b0;
    for (int k = 0; k < LB; k++) begin
      resp_valid = 1'b1;
      resp_data  = beat_vals[k];
      #2;
      dg = {o_data_we, o_data_index, o_data_beat, o_data_wdata, o_tag_we, o_refill_done};
      de = {1'b1, 6'h11, BI'(k), beat_vals[k], 1'b0, 1'b0};
      n_cmp++;
      if (dg !== de) begin
        n_err++;
        $display("FAIL refill_beat[%0d]: got %h expected %h", k, dg, de);
      end
      next_cycle();
    end
    resp_valid = 1'b0;
    #2;
    tg = {o_tag_we, o_tag_index, o_tag_value, o_tag_valid, o_refill_done};
    te = {1'b1, 6'h11, 21'h2, 1'b1, 1'b1};
    n_cmp++;
    if (tg !== te || o_data_we !== 1'b0) begin
      n_err++;
      $display("FAIL refill_tag: got %h/%b expected %h/0", tg, o_data_we, te);
    end
    next_cycle();
    #2;
    n_cmp++;
    if ({o_miss_ready, o_busy, o_tag_we} !== 3'b100) begin
      n_err++;
      $display("FAIL refill_idle: got %b expected 100", {o_miss_ready, o_busy, o_tag_we});
    end
    next_cycle();
    model_commit(32'h0000_1234);
  endtask

  task automatic test_gapped();
    bit to;
    int acc, e;
    logic [PW-1:0] pa;
    pa = $urandom;
    for (int k = 0; k < LB; k++) beat_vals[k] = $urandom;
    run_refill(pa, 2, 1, to, acc);
    e = refill_errs(pa);
    n_cmp++;
    if (to || e != 0) begin
      n_err++;
      $display("FAIL gapped_refill: got timeout=%0d errs=%0d expected 0/0", to, e);
    end
    model_commit(pa);
  endtask

  task automatic test_flush_priority();
    bit to, bad;
    int acc, done_cyc, e;
    logic [PW-1:0] pa;
    pa = 32'h0000_4560;
    for (int k = 0; k < LB; k++) beat_vals[k] = $urandom;
    clear_logs();
    flush = 1'b1;
    miss_valid = 1'b1;
    miss_paddr = pa;
    #2;
    n_cmp++;
    if (o_miss_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_prio_ready: got %b expected 0", o_miss_ready);
    end
    next_cycle();
    flush = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < NSETS; k++) begin
      #2;
      if (o_miss_ready !== 1'b0 || o_busy !== 1'b1) bad = 1'b1;
      next_cycle();
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL flush_prio_busy: got miss_ready/idle during sweep expected busy");
    end
    e = 0;
    if (tlog.size() != NSETS) e++;
    else for (int k = 0; k < NSETS; k++)
      if (tlog[k].idx != k || tlog[k].valid !== 1'b0 || tlog[k].tag !== '0 ||
          tlog[k].done !== (k == NSETS - 1) || (k > 0 && tlog[k].cyc != tlog[k-1].cyc + 1)) e++;
    n_cmp++;
    if (e != 0 || dlog.size() != 0) begin
      n_err++;
      $display("FAIL flush_prio_sweep: got %0d tag writes, %0d bad, %0d data writes expected 64/0/0",
               tlog.size(), e, dlog.size());
    end
    done_cyc = (tlog.size() > 0) ? tlog[tlog.size()-1].cyc : -100;
    model_invalidate_all();
    run_refill(pa, 0, 0, to, acc);
    e = refill_errs(pa);
    n_cmp++;
    if (to || acc != done_cyc + 1 || e != 0) begin
      n_err++;
      $display("FAIL flush_prio_miss: got timeout=%0d acc_cyc=%0d errs=%0d expected 0/%0d/0",
               to, acc, e, done_cyc + 1);
    end
    model_commit(pa);
  endtask

  task automatic test_reset_mid_refill();
    int e, vcount;
    for (int k = 0; k < LB; k++) beat_vals[k] = $urandom;
    clear_logs();
    miss_valid = 1'b1;
    miss_paddr = 32'h0000_1234;
    next_cycle();
    miss_valid = 1'b0;
    req_ready = 1'b1;
    next_cycle();
    req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      resp_valid = 1'b1;
      resp_data  = beat_vals[k];
      next_cycle();
    end
    resp_data = beat_vals[5];
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h expected 0", all_out);
    end
    next_cycle();
    next_cycle();
    model_invalidate_all();
    rst_n = 1'b1;
    for (int k = 0; k < NSETS; k++) begin
      resp_valid = 1'b1;
      resp_data  = $urandom;
      next_cycle();
    end
    resp_valid = 1'b0;
    vcount = 0;
    e = 0;
    foreach (tlog[i]) if (tlog[i].valid !== 1'b0) vcount++;
    if (tlog.size() != NSETS) e++;
    else for (int k = 0; k < NSETS; k++) if (tlog[k].idx != k) e++;
    n_cmp++;
    if (dlog.size() != 5 || vcount != 0) begin
      n_err++;
      $display("FAIL midreset_abort: got %0d data writes, %0d valid tag writes expected 5/0",
               dlog.size(), vcount);
    end
    n_cmp++;
    if (e != 0) begin
      n_err++;
      $display("FAIL midreset_sweep: got %0d tag writes, %0d misordered expected 64/0", tlog.size(), e);
    end
    #2;
    n_cmp++;
    if (o_miss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_idle: got %b expected 1", o_miss_ready);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bit to;
    int acc, e, done_cyc;
    for (int k = 0; k < LB; k++) beat_vals[k] = $urandom;
    run_refill(32'h0000_1234, 1, 0, to, acc);
    e = refill_errs(32'h0000_1234);
    n_cmp++;
    if (to || e != 0) begin
      n_err++;
      $display("FAIL b2b_first: got timeout=%0d errs=%0d expected 0/0", to, e);
    end
    model_commit(32'h0000_1234);
    done_cyc = (tlog.size() > 0) ? tlog[0].cyc : -100;
    for (int k = 0; k < LB; k++) beat_vals[k] = $urandom;
    run_refill(32'h0000_FFE0, 0, 0, to, acc);
    e = refill_errs(32'h0000_FFE0);
    n_cmp++;
    if (to || e != 0 || acc != done_cyc + 1) begin
      n_err++;
      $display("FAIL b2b_second: got timeout=%0d errs=%0d acc_cyc=%0d expected 0/0/%0d",
               to, e, acc, done_cyc + 1);
    end
    n_cmp++;
    if (tlog.size() != 1 || tlog[0].idx != 'h3F || tlog[0].tag !== 21'h1F) begin
      n_err++;
      $display("FAIL b2b_tag: got %0d writes idx=%0h tag=%0h expected 1/3f/1f",
               tlog.size(), (tlog.size() > 0) ? tlog[0].idx : -1,
               (tlog.size() > 0) ? tlog[0].tag : '1);
    end
    model_commit(32'h0000_FFE0);
  endtask

  task automatic test_random();
    bit to, got;
    int acc, e, n;
    logic [PW-1:0] pa;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
          #2;
          if (o_refill_done) got = 1'b1;
          next_cycle();
          n++;
        end
        model_invalidate_all();
        n_cmp++;
        if (!got || n != NSETS) begin
          n_err++;
          $display("FAIL rand_flush[%0d]: got done=%0d after %0d cycles expected 1 after 64", t, got, n);
        end
      end else begin
        pa = $urandom;
        for (int k = 0; k < LB; k++) beat_vals[k] = $urandom;
        run_refill(pa, int'($urandom_range(0, 4)), 2, to, acc);
        e = refill_errs(pa);
        n_cmp++;
        if (to || e != 0) begin
          n_err++;
          $display("FAIL rand_refill[%0d] pa=%h: got timeout=%0d errs=%0d expected 0/0", t, pa, to, e);
        end
        model_commit(pa);
      end
    end
    for (int s = 0; s < NSETS; s++) begin
      int dbad;
      dbad = 0;
      if (mv[s]) for (int k = 0; k < LB; k++) if (sh_data[s][k] !== md[s][k]) dbad++;
      n_cmp++;
      if (sh_valid[s] !== mv[s] || (mv[s] && sh_tag[s] !== mt[s]) || dbad != 0) begin
        n_err++;
        $display("FAIL rand_array[%0d]: got v=%b tag=%h bad_beats=%0d expected v=%b tag=%h",
                 s, sh_valid[s], sh_tag[s], dbad, mv[s], mt[s]);
      end
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (viol != 0) begin
      n_err++;
      $display("FAIL protocol_invariants: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_refill();
    test_gapped();
    test_flush_priority();
    test_back_to_back();
    test_reset_mid_refill();
    test_random();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_cache_refill.md
INSTR_CACHE_REFILL -- requirements
Module: instr_cache_refill

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- PADDR_WIDTH, 32, physical address width.
- INDEX_WIDTH, 6, set-index bits (64 sets).
- LINE_BEATS, 8, beats per cache line (power of 2).
- BEAT_WIDTH, 32, bits per beat (power of 2, multiple of 8).

REQ-002 Derived widths SHALL be: OFFSET_WIDTH = log2(LINE_BEATS*BEAT_WIDTH/8); TAG_WIDTH = PADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH; BEAT_IDX = log2(LINE_BEATS).

REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset; asynchronous, active-low.
- i_miss_valid, in, 1, fetch miss pending.
- i_miss_paddr, in, PADDR_WIDTH, missing physical address.
- o_miss_ready, out, 1, miss accepted.
- i_flush, in, 1, invalidate-all request.
- o_mem_req_valid, out, 1, line read request.
- i_mem_req_ready, in, 1, memory accepts request.
- o_mem_req_addr, out, PADDR_WIDTH, line-aligned address.
- i_mem_resp_valid, in, 1, beat valid.
- i_mem_resp_data, in, BEAT_WIDTH, beat data, in ascending beat order.
- o_data_we, out, 1, data array write enable.
- o_data_index, out, INDEX_WIDTH, set to write.
- o_data_beat, out, BEAT_IDX, beat slot.
- o_data_wdata, out, BEAT_WIDTH, beat data.
- o_tag_we, out, 1, tag array write enable.
- o_tag_index, out, INDEX_WIDTH, set to write.
- o_tag_value, out, TAG_WIDTH, tag written.
- o_tag_valid, out, 1, valid bit written.
- o_refill_done, out, 1, one-cycle pulse when a refill or flush completes.
- o_busy, out, 1, high in any state other than IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, REQ, FILL, TAG and FLUSH.

REQ-005 IDLE: i_flush=1 SHALL go to FLUSH with sweep counter 0; otherwise i_miss_valid=1 SHALL go to REQ. i_flush has priority when both are asserted in the same cycle.

REQ-006 o_miss_ready SHALL equal (state==IDLE && !i_flush), combinationally. On a miss handshake, i_miss_paddr SHALL be latched.

REQ-007 REQ: o_mem_req_valid=1 and o_mem_req_addr = latched paddr with OFFSET_WIDTH LSBs zeroed. Address SHALL be held stable until i_mem_req_ready=1, then go to FILL with beat counter 0.

REQ-008 FILL: each cycle with i_mem_resp_valid=1 SHALL assert o_data_we in the same cycle, with o_data_beat=counter, o_data_wdata=i_mem_resp_data and o_data_index=latched index; the counter then increments. Cycles without a valid beat SHALL write nothing.

REQ-009 The beat with counter==LINE_BEATS-1 SHALL move the FSM to TAG. The counter wraps to 0; there is no overflow state.

REQ-010 TAG, exactly one cycle: o_tag_we=1, o_tag_index=latched index, o_tag_value=latched paddr[PADDR_WIDTH-1 -: TAG_WIDTH], o_tag_valid=1, o_refill_done=1; then IDLE.

REQ-011 The tag SHALL be written only after all data beats, so a lookup never hits a partially filled line.

REQ-012 FLUSH: each cycle o_tag_we=1, o_tag_index=counter, o_tag_valid=0, o_tag_value=0. When counter == 2^INDEX_WIDTH-1, assert o_refill_done and go to IDLE; sweep takes 2^INDEX_WIDTH cycles.

REQ-013 i_miss_valid and i_flush SHALL be ignored outside IDLE. i_mem_resp_valid SHALL be ignored outside FILL.

REQ-014 o_data_we and o_tag_we SHALL never be asserted in the same cycle.

REQ-015 o_data_index, o_data_beat, o_data_wdata, o_tag_index, o_tag_value and o_tag_valid SHALL drive 0 whenever their write enable is 0.

Reset
REQ-016 While i_rst_n=0, all outputs SHALL be 0 and all counters and latched registers SHALL be cleared.

REQ-017 The FSM SHALL be in FLUSH with counter 0 during reset, so the first 2^INDEX_WIDTH cycles after release invalidate every tag; o_busy=1 then.

REQ-018 A reset asserted mid-refill or mid-flush SHALL abort it immediately with no further writes. Beats returned after release for the aborted request are ignored by REQ-013.

Verification
REQ-019 Post-reset sweep: release i_rst_n -> 64 consecutive o_tag_we cycles, index 0..63, o_tag_valid=0, o_refill_done on index 63; o_miss_ready=1 the next cycle.

REQ-020 Refill: miss paddr 0x00001234; i_mem_req_ready held 0 for 3 cycles, then 1 -> o_mem_req_addr=0x00001220, stable throughout.
- Then 8 beats 0xA0..0xA7 -> data writes at index 0x11, beats 0..7.
- Then one tag write: index 0x11, tag 0x2, valid=1, o_refill_done=1.

REQ-021 Gapped response: beats with i_mem_resp_valid low on alternating cycles -> exactly 8 data writes, beat numbers contiguous, tag write one cycle after the last beat.

REQ-022 Simultaneous i_flush=1 and i_miss_valid=1 in IDLE -> o_miss_ready=0, full flush sweep; the miss is then accepted in IDLE.

REQ-023 Reset asserted after beat 4 of a refill -> outputs 0 immediately, no tag write for index 0x11, fresh 64-entry sweep after release.

REQ-024 Back-to-back misses 0x00001234 then 0x0000FFE0 -> the second is accepted in the IDLE cycle after the first o_refill_done; it writes index 0x3F with tag 0x1F.
